// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: next-PC select codes, the NOP encoding and
// the default ROM base, plus the branch-offset helper used by the PC adder.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npcSel_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Word-scaled, sign-extended 16-bit branch immediate.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Combinational next-PC selection for the fetch stage: sequential, taken
// branch, j/jal and jr targets, chosen by the decode-stage redirect code.
module npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc4_d_i,
  input  logic [31:0] instr_d_i,
  input  logic [31:0] rs_value_i,
  input  logic [1:0]  npc_sel_i,
  output logic [31:0] npc_o
);

  logic [31:0] seqTarget;
  logic [31:0] brTarget;
  logic [31:0] jmpTarget;
  logic        unusedOpcode;

  assign seqTarget    = pc_f_i + 32'd4;
  assign brTarget     = pc4_d_i + branchOffset(instr_d_i[15:0]);
  assign jmpTarget    = {pc4_d_i[31:28], instr_d_i[25:0], 2'b00};
  assign unusedOpcode = ^instr_d_i[31:26];

  // Wrap-around at 2^32 is deliberately not trapped; the range check on the
  // next fetch catches it.
  always_comb begin
    npc_o = seqTarget;
    case (npc_sel_i)
      NPC_SEQ: npc_o = seqTarget;
      NPC_BR:  npc_o = brTarget;
      NPC_J:   npc_o = jmpTarget;
      NPC_JR:  npc_o = rs_value_i;
      default: npc_o = seqTarget;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS core: PC register, ROM addressing, fetch-range
// check and the IF/ID pipeline register with flush-over-stall priority.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] rs_value,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        fetch_err_d
);

  // One bit wider than the PC so a ROM ending exactly at 2^32 still compares.
  localparam logic [32:0] FETCH_END = {1'b0, RESET_PC} + (33'(IMEM_WORDS) * 33'd4);

  logic [31:0] pcF_q;
  logic [31:0] pcF_d;
  logic [31:0] instrD_q;
  logic [31:0] pcD_q;
  logic [31:0] pc4D_q;
  logic        fetchErrD_q;
  logic [31:0] pc4F;
  logic        fetchErrF;

  assign pc4F      = pcF_q + 32'd4;
  assign imem_addr = pcF_q[13:2];
  assign fetchErrF = (pcF_q[1:0] != 2'b00)
                   | (pcF_q < RESET_PC)
                   | ({1'b0, pcF_q} >= FETCH_END);

  npc_calc u_npc_calc (
    .pc_f_i     (pcF_q),
    .pc4_d_i    (pc4D_q),
    .instr_d_i  (instrD_q),
    .rs_value_i (rs_value),
    .npc_sel_i  (npc_sel),
    .npc_o      (pcF_d)
  );

  // Flush bubbles IF/ID even under stall, but the PC still honours the stall.
  // A bad fetch enters decode as a NOP tagged with the error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcF_q       <= RESET_PC;
      instrD_q    <= NOP;
      pcD_q       <= '0;
      pc4D_q      <= '0;
      fetchErrD_q <= 1'b0;
    end else if (flush) begin
      instrD_q    <= NOP;
      fetchErrD_q <= 1'b0;
      pcD_q       <= pcF_q;
      pc4D_q      <= pc4F;
      if (!stall) begin
        pcF_q <= pcF_d;
      end
    end else if (!stall) begin
      pcF_q       <= pcF_d;
      instrD_q    <= fetchErrF ? NOP : imem_instr;
      pcD_q       <= pcF_q;
      pc4D_q      <= pc4F;
      fetchErrD_q <= fetchErrF;
    end
  end

  assign pc_f        = pcF_q;
  assign instr_d     = instrD_q;
  assign pc_d        = pcD_q;
  assign pc4_d       = pc4D_q;
  assign fetch_err_d = fetchErrD_q;

endmodule
